dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the byte-addressable 512-byte data memory. It lets the pipeline MEM stage (port 0) and a program/data loader or debug port (port 1) share the memory's single A/DI/Size/RW/E/DO port. It uses round-robin arbitration, a registered command stage, alignment checking and a per-port response handshake. It sits between the requesters and the data memory; the memory's read path stays combinational and its write path synchronous.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_rr_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the two-port data-memory arbiter:
// access-size codes, FSM state encoding and default bus widths.
package dmem_pkg;

    localparam int AW_DEFAULT = 9;
    localparam int DW_DEFAULT = 32;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arbState_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// and on contention the port that was not granted last time wins.
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_lastGrant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req0 && i_req1) begin
            o_grant = i_lastGrant ? 2'b01 : 2'b10;
        end else if (i_req0) begin
            o_grant = 2'b01;
        end else if (i_req1) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the 512-byte data memory: grant in IDLE,
// drive the memory for one ACCESS cycle, then pulse the owner's response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [1:0]    size0,
    input  logic [1:0]    size1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rsp_valid0,
    output logic          rsp_valid1,
    output logic          rsp_err0,
    output logic          rsp_err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_DI,
    output logic [1:0]    mem_Size,
    output logic          mem_RW,
    output logic          mem_E,
    input  logic [DW-1:0] mem_DO,
    output logic          busy
);

    logic [1:0]    w_grant;
    logic          w_take;
    logic          w_selPort;
    logic          w_selRw;
    logic [1:0]    w_selSize;
    logic [AW-1:0] w_selAddr;
    logic [DW-1:0] w_selWdata;
    logic          w_selErr;
    logic          w_access;
    logic [DW-1:0] w_readData;

    arbState_t     r_state;
    logic          r_lastGrant;
    logic          r_cmdPort;
    logic          r_cmdRw;
    logic          r_cmdErr;
    logic [1:0]    r_cmdSize;
    logic [AW-1:0] r_cmdAddr;
    logic [DW-1:0] r_cmdWdata;
    logic          r_rspValid0;
    logic          r_rspValid1;
    logic          r_rspErr0;
    logic          r_rspErr1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    dmem_rr_pick u_pick (
        .i_req0      (req0),
        .i_req1      (req1),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant)
    );

    // Grant is combinational so the requester sees it in the cycle it is accepted.
    assign w_take = (r_state == ST_IDLE) && !reset && (w_grant != 2'b00);
    assign gnt0   = w_take && w_grant[0];
    assign gnt1   = w_take && w_grant[1];

    assign w_selPort  = w_grant[1];
    assign w_selRw    = w_selPort ? rw1    : rw0;
    assign w_selSize  = w_selPort ? size1  : size0;
    assign w_selAddr  = w_selPort ? addr1  : addr0;
    assign w_selWdata = w_selPort ? wdata1 : wdata0;

    always_comb begin
        w_selErr = 1'b1;
        case (w_selSize)
            SIZE_BYTE:    w_selErr = 1'b0;
            SIZE_HALF:    w_selErr = w_selAddr[0];
            SIZE_WORD:    w_selErr = (w_selAddr[1:0] != 2'b00);
            SIZE_ILLEGAL: w_selErr = 1'b1;
        endcase
    end

    // The memory only sees a command during ACCESS; a reset in that cycle kills the write.
    assign w_access   = (r_state == ST_ACCESS);
    assign mem_A      = w_access ? r_cmdAddr  : '0;
    assign mem_DI     = w_access ? r_cmdWdata : '0;
    assign mem_Size   = w_access ? r_cmdSize  : 2'b00;
    assign mem_RW     = w_access && r_cmdRw;
    assign mem_E      = w_access && r_cmdRw && !r_cmdErr && !reset;
    assign w_readData = (r_cmdRw || r_cmdErr) ? '0 : mem_DO;

    assign busy       = (r_state != ST_IDLE);
    assign rsp_valid0 = r_rspValid0;
    assign rsp_valid1 = r_rspValid1;
    assign rsp_err0   = r_rspErr0;
    assign rsp_err1   = r_rspErr1;
    assign rdata0     = r_rdata0;
    assign rdata1     = r_rdata1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lastGrant <= 1'b1;
            r_cmdPort   <= 1'b0;
            r_cmdRw     <= 1'b0;
            r_cmdErr    <= 1'b0;
            r_cmdSize   <= 2'b00;
            r_cmdAddr   <= '0;
            r_cmdWdata  <= '0;
            r_rspValid0 <= 1'b0;
            r_rspValid1 <= 1'b0;
            r_rspErr0   <= 1'b0;
            r_rspErr1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_rspValid0 <= 1'b0;
            r_rspValid1 <= 1'b0;
            r_rspErr0   <= 1'b0;
            r_rspErr1   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_cmdPort   <= w_selPort;
                        r_cmdRw     <= w_selRw;
                        r_cmdSize   <= w_selSize;
                        r_cmdAddr   <= w_selAddr;
                        r_cmdWdata  <= w_selWdata;
                        r_cmdErr    <= w_selErr;
                        r_lastGrant <= w_selPort;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Response flags and read data land together so they are visible in RESP.
                    if (r_cmdPort) begin
                        r_rspValid1 <= 1'b1;
                        r_rspErr1   <= r_cmdErr;
                        r_rdata1    <= w_readData;
                    end else begin
                        r_rspValid0 <= 1'b1;
                        r_rspErr0   <= r_cmdErr;
                        r_rdata0    <= w_readData;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a big-endian byte memory device, a
// transaction-timeline reference model checked every cycle, and directed tests.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          rw0 = 1'b0, rw1 = 1'b0;
    logic [1:0]    size0 = 2'b00, size1 = 2'b00;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_DI;
    logic [1:0]    mem_Size;
    logic          mem_RW, mem_E;
    logic [DW-1:0] mem_DO;
    logic          busy;

    int numVectors = 0;
    int numMiscompares = 0;
    int cyc = 0;

    logic [7:0] devMem [512];
    logic       devInit = 1'b0;
    logic [7:0] refMem [512];

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_err0(rsp_err0), .rsp_err1(rsp_err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_A(mem_A), .mem_DI(mem_DI), .mem_Size(mem_Size),
        .mem_RW(mem_RW), .mem_E(mem_E), .mem_DO(mem_DO),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: big-endian, combinational read, synchronous write.
    always_comb begin
        case (mem_Size)
            2'b00:   mem_DO = {24'h0, devMem[mem_A]};
            2'b01:   mem_DO = {16'h0, devMem[mem_A], devMem[mem_A + 9'd1]};
            default: mem_DO = {devMem[mem_A], devMem[mem_A + 9'd1],
                               devMem[mem_A + 9'd2], devMem[mem_A + 9'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (!devInit) begin
            for (int i = 0; i < 512; i++) devMem[i] <= 8'(i);
            devInit <= 1'b1;
        end else if (mem_E) begin
            case (mem_Size)
                2'b00: devMem[mem_A] <= mem_DI[7:0];
                2'b01: begin
                    devMem[mem_A]        <= mem_DI[15:8];
                    devMem[mem_A + 9'd1] <= mem_DI[7:0];
                end
                default: begin
                    devMem[mem_A]        <= mem_DI[31:24];
                    devMem[mem_A + 9'd1] <= mem_DI[23:16];
                    devMem[mem_A + 9'd2] <= mem_DI[15:8];
                    devMem[mem_A + 9'd3] <= mem_DI[7:0];
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numVectors++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit specErr(input logic [1:0] s, input int a);
        return (s == 2'b11) || (s == 2'b01 && a % 2 != 0) || (s == 2'b10 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] refRead(input int a, input logic [1:0] s);
        case (s)
            2'b00:   return {24'h0, refMem[a]};
            2'b01:   return {16'h0, refMem[a], refMem[(a + 1) % 512]};
            default: return {refMem[a], refMem[(a + 1) % 512], refMem[(a + 2) % 512], refMem[(a + 3) % 512]};
        endcase
    endfunction

    function automatic void refWrite(input int a, input logic [1:0] s, input logic [31:0] d);
        case (s)
            2'b00: refMem[a] = d[7:0];
            2'b01: begin refMem[a] = d[15:8]; refMem[(a + 1) % 512] = d[7:0]; end
            default: begin
                refMem[a] = d[31:24];             refMem[(a + 1) % 512] = d[23:16];
                refMem[(a + 2) % 512] = d[15:8]; refMem[(a + 3) % 512] = d[7:0];
            end
        endcase
    endfunction

    // Reference model: one transaction in flight, granted at cycle g, memory at g+1, response at g+2.
    int          mFreeAt = 0, mLastWin = 1, mGrantCyc = 0, mPort = 0, mAddr = 0;
    bit          mActive = 0, mRw = 0, mErr = 0;
    logic [1:0]  mSize = 2'b00;
    logic [31:0] mWdata = '0;
    logic [31:0] mHeld [2];

    initial begin : modelProc
        int c, phase, win;
        logic [1:0] eGnt, eValid, eErr, eSize;
        logic [31:0] eA, eDI;
        logic eRW, eE, eBusy;
        for (int i = 0; i < 512; i++) refMem[i] = 8'(i);
        mHeld[0] = '0;
        mHeld[1] = '0;
        forever begin
            @(negedge clk);
            c = cyc;
            phase = mActive ? (c - mGrantCyc) : 0;
            eGnt = 2'b00; eValid = 2'b00; eErr = 2'b00; eSize = 2'b00;
            eA = '0; eDI = '0; eRW = 1'b0; eE = 1'b0; eBusy = 1'b0;
            if (phase == 1) begin
                eBusy = 1'b1; eA = 32'(mAddr); eDI = mWdata; eSize = mSize;
                eRW = mRw; eE = mRw && !mErr && !reset;
            end
            if (phase == 2) begin
                eBusy = 1'b1; eValid[mPort] = 1'b1; eErr[mPort] = mErr;
            end
            win = -1;
            if (!reset && c >= mFreeAt && (req0 || req1)) begin
                win = (req0 && req1) ? (1 - mLastWin) : (req0 ? 0 : 1);
                eGnt[win] = 1'b1;
            end
            checkOutput("gnt0", 32'(gnt0), 32'(eGnt[0]));
            checkOutput("gnt1", 32'(gnt1), 32'(eGnt[1]));
            checkOutput("mem_A", 32'(mem_A), eA);
            checkOutput("mem_DI", mem_DI, eDI);
            checkOutput("mem_Size", 32'(mem_Size), 32'(eSize));
            checkOutput("mem_RW", 32'(mem_RW), 32'(eRW));
            checkOutput("mem_E", 32'(mem_E), 32'(eE));
            checkOutput("busy", 32'(busy), 32'(eBusy));
            checkOutput("rsp_valid0", 32'(rsp_valid0), 32'(eValid[0]));
            checkOutput("rsp_valid1", 32'(rsp_valid1), 32'(eValid[1]));
            checkOutput("rsp_err0", 32'(rsp_err0), 32'(eErr[0]));
            checkOutput("rsp_err1", 32'(rsp_err1), 32'(eErr[1]));
            checkOutput("rdata0", rdata0, mHeld[0]);
            checkOutput("rdata1", rdata1, mHeld[1]);
            if (reset) begin
                mActive = 0; mHeld[0] = '0; mHeld[1] = '0; mLastWin = 1; mFreeAt = c + 1;
            end else begin
                if (phase == 1) begin
                    mHeld[mPort] = (mRw || mErr) ? 32'h0 : refRead(mAddr, mSize);
                    if (mRw && !mErr) refWrite(mAddr, mSize, mWdata);
                end
                if (phase == 2) mActive = 0;
                if (win >= 0) begin
                    mActive = 1; mGrantCyc = c; mPort = win; mLastWin = win; mFreeAt = c + 3;
                    mRw    = (win == 1) ? rw1 : rw0;
                    mSize  = (win == 1) ? size1 : size0;
                    mAddr  = (win == 1) ? int'(addr1) : int'(addr0);
                    mWdata = (win == 1) ? wdata1 : wdata0;
                    mErr   = specErr(mSize, mAddr);
                end
            end
        end
    end

    task automatic applyStimulus(input int port, input bit rw, input logic [1:0] size,
                                 input logic [8:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output bit err,
                                 output int gntCyc, output int rspCyc);
        bit seen;
        rdata = '0; err = 1'b0; gntCyc = -1; rspCyc = -1;
        @(posedge clk); #1;
        if (port == 0) begin req0 = 1; rw0 = rw; size0 = size; addr0 = addr; wdata0 = wdata; end
        else begin req1 = 1; rw1 = rw; size1 = size; addr1 = addr; wdata1 = wdata; end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((port == 0) ? gnt0 : gnt1) begin seen = 1; gntCyc = cyc; end
        end
        @(posedge clk); #1;
        if (port == 0) req0 = 0; else req1 = 0;
        if (!seen) begin
            checkOutput("gnt timeout", 32'(port), 32'hFFFF_FFFF);
            return;
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((port == 0) ? rsp_valid0 : rsp_valid1) begin
                seen = 1; rspCyc = cyc;
                rdata = (port == 0) ? rdata0 : rdata1;
                err   = (port == 0) ? rsp_err0 : rsp_err1;
            end
        end
        if (!seen) checkOutput("rsp timeout", 32'(port), 32'hFFFF_FFFF);
    endtask

    logic [31:0] rd0, rd1;
    bit          er0, er1;
    int          g0, g1, rc0, rc1;

    initial begin : mainProc
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset rdata0", rdata0, 32'h0);

        // Contention out of reset: port 0 first, then port 1.
        fork
            applyStimulus(0, 0, SIZE_WORD, 9'h040, 32'h0, rd0, er0, g0, rc0);
            applyStimulus(1, 0, SIZE_BYTE, 9'h055, 32'h0, rd1, er1, g1, rc1);
        join
        checkOutput("contend1 order", 32'(g1 - g0), 32'd3);
        checkOutput("contend1 rd0", rd0, 32'h40414243);
        checkOutput("contend1 rd1", rd1, 32'h00000055);
        fork
            applyStimulus(0, 1, SIZE_HALF, 9'h060, 32'h0000A1B2, rd0, er0, g0, rc0);
            applyStimulus(1, 0, SIZE_HALF, 9'h060, 32'h0, rd1, er1, g1, rc1);
        join
        checkOutput("contend2 order", 32'(g1 - g0), 32'd3);
        checkOutput("contend2 rd1", rd1, 32'h0000A1B2);

        // Word write/read and byte read, back to back from port 0.
        applyStimulus(0, 1, SIZE_WORD, 9'h010, 32'hDEADBEEF, rd0, er0, g0, rc0);
        checkOutput("write latency", 32'(rc0 - g0), 32'd2);
        checkOutput("write rdata", rd0, 32'h0);
        applyStimulus(0, 0, SIZE_WORD, 9'h010, 32'h0, rd0, er0, g0, rc0);
        checkOutput("word read", rd0, 32'hDEADBEEF);
        applyStimulus(0, 0, SIZE_BYTE, 9'h011, 32'h0, rd0, er0, g0, rc0);
        checkOutput("byte read", rd0, 32'h000000AD);

        // Misaligned and illegal accesses.
        applyStimulus(0, 1, SIZE_HALF, 9'h003, 32'h0000BEEF, rd0, er0, g0, rc0);
        checkOutput("half 0x003 err", 32'(er0), 32'h1);
        applyStimulus(0, 0, SIZE_WORD, 9'h102, 32'h0, rd0, er0, g0, rc0);
        checkOutput("word 0x102 err", 32'(er0), 32'h1);
        checkOutput("word 0x102 rdata", rd0, 32'h0);
        applyStimulus(1, 1, SIZE_ILLEGAL, 9'h010, 32'hFFFFFFFF, rd1, er1, g1, rc1);
        checkOutput("size11 err", 32'(er1), 32'h1);
        checkOutput("size11 latency", 32'(rc1 - g1), 32'd2);
        applyStimulus(0, 0, SIZE_WORD, 9'h000, 32'h0, rd0, er0, g0, rc0);
        checkOutput("unchanged 0x000", rd0, 32'h00010203);
        applyStimulus(1, 0, SIZE_WORD, 9'h010, 32'h0, rd1, er1, g1, rc1);
        checkOutput("unchanged 0x010", rd1, 32'hDEADBEEF);

        // Top-of-memory boundary.
        applyStimulus(1, 1, SIZE_WORD, 9'h1FC, 32'h11223344, rd1, er1, g1, rc1);
        checkOutput("word 0x1FC err", 32'(er1), 32'h0);
        applyStimulus(1, 0, SIZE_BYTE, 9'h1FF, 32'h0, rd1, er1, g1, rc1);
        checkOutput("byte 0x1FF", rd1, 32'h00000044);
        applyStimulus(1, 0, SIZE_HALF, 9'h1FE, 32'h0, rd1, er1, g1, rc1);
        checkOutput("half 0x1FE", rd1, 32'h00003344);

        // Reset during the ACCESS cycle of a write.
        applyStimulus(0, 1, SIZE_WORD, 9'h020, 32'h12345678, rd0, er0, g0, rc0);
        @(posedge clk); #1;
        req0 = 1; rw0 = 1; size0 = SIZE_WORD; addr0 = 9'h020; wdata0 = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("abort gnt0", 32'(gnt0), 32'h1);
        @(posedge clk); #1;
        req0 = 0; reset = 1;
        @(negedge clk);
        checkOutput("abort mem_E", 32'(mem_E), 32'h0);
        checkOutput("abort mem_A", 32'(mem_A), 32'h020);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort rsp_valid0", 32'(rsp_valid0), 32'h0);
        applyStimulus(0, 0, SIZE_WORD, 9'h020, 32'h0, rd0, er0, g0, rc0);
        checkOutput("abort read", rd0, 32'h12345678);

        // Port 1 raises its request during port 0's ACCESS and holds it.
        fork
            applyStimulus(0, 0, SIZE_WORD, 9'h010, 32'h0, rd0, er0, g0, rc0);
            begin
                @(posedge clk);
                applyStimulus(1, 0, SIZE_WORD, 9'h1FC, 32'h0, rd1, er1, g1, rc1);
            end
        join
        checkOutput("held gnt1 delay", 32'(g1 - g0), 32'd3);
        checkOutput("held rd0", rd0, 32'hDEADBEEF);
        checkOutput("held rd1", rd1, 32'h11223344);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
